// File: rtl/memtile_stream_rx_downsample_pkg.sv
// Shared types and helpers for the memtile read-stream receiver.
//   PIXEL_W     : default pixel width (memtile data_out lane width)
//   pixel_t     : one pixel
//   rx_entry_t  : FIFO entry layout {last, data}
//   clog2_min1  : ceil(log2(n)), never less than 1 (safe width for counters)
package memtile_rx_pkg;

    localparam int PIXEL_W = 16;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef struct packed {
        logic   last;
        pixel_t data;
    } rx_entry_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/memtile_stream_rx_downsample_if.sv
// Stream bundle between the memtile read port, the down-sampler and the
// downstream consumer.
//   in_valid/in_data          : memtile valid_out / data_out lane 0 (no backpressure)
//   out_valid/out_ready       : downstream ready/valid handshake
//   out_data/out_last         : head pixel and its end-of-frame marker
//   overflow                  : sticky pixel-loss flag
// master = the side feeding pixels and consuming results; slave = the receiver.
interface memtile_stream_rx_downsample_if #(
    parameter int DATA_WIDTH = memtile_rx_pkg::PIXEL_W
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  overflow;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last, overflow
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last, overflow
    );
endinterface

// File: rtl/memtile_stream_rx_downsample_fifo.sv
// rx_fifo: synchronous first-word-fall-through buffer.
//   clk, rst_n (async low), flush (sync clear, wins over push/pop)
//   push/din  : write request; accepted when not full or when popping same cycle
//   pop/dout  : read request; ignored when empty; dout is 0 when empty
//   full/empty: occupancy flags
module rx_fifo
    import memtile_rx_pkg::*;
#(
    parameter int WIDTH = PIXEL_W + 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = clog2_min1(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write if the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty gating on dout hides stale entries.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/memtile_stream_rx_downsample.sv
// Receive side of the memtile read stream. Tracks raster x/y of every valid
// input pixel, keeps pixels on the STRIDE grid, buffers them in a small FIFO
// and presents them downstream with an end-of-frame marker. The input cannot
// be stalled, so a kept pixel arriving at a full, non-draining FIFO is lost
// and the sticky overflow flag is raised.
//   clk, rst_n (async low), flush (sync clear)
//   bus : slave side of memtile_stream_rx_downsample_if
module memtile_stream_rx_downsample
    import memtile_rx_pkg::*;
#(
    parameter int DATA_WIDTH = PIXEL_W,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int STRIDE     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    memtile_stream_rx_downsample_if.slave bus
);
    localparam int XW = clog2_min1(IMG_W);
    localparam int YW = clog2_min1(IMG_H);
    localparam int SW = clog2_min1(STRIDE);

    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
    localparam logic [SW-1:0] S_MAX = SW'(STRIDE - 1);
    // Coordinates of the last on-grid pixel in a frame.
    localparam logic [XW-1:0] LX = XW'(((IMG_W - 1) / STRIDE) * STRIDE);
    localparam logic [YW-1:0] LY = YW'(((IMG_H - 1) / STRIDE) * STRIDE);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    // Per-axis phase within the stride; zero means on-grid. Avoids a divider.
    logic [SW-1:0] sx, sy;

    logic                  keep, pix_last, pop, full, empty, overflow_q;
    logic [DATA_WIDTH:0]   din, dout;

    assign keep     = bus.in_valid && (sx == '0) && (sy == '0);
    assign pix_last = (x == LX) && (y == LY);
    assign pop      = !empty && bus.out_ready;
    assign din      = {pix_last, bus.in_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x  <= '0;
            y  <= '0;
            sx <= '0;
            sy <= '0;
        end else if (flush) begin
            x  <= '0;
            y  <= '0;
            sx <= '0;
            sy <= '0;
        end else if (bus.in_valid) begin
            if (x == X_MAX) begin
                x  <= '0;
                sx <= '0;
                if (y == Y_MAX) begin
                    y  <= '0;
                    sy <= '0;
                end else begin
                    y  <= y + 1'b1;
                    sy <= (sy == S_MAX) ? '0 : sy + 1'b1;
                end
            end else begin
                x  <= x + 1'b1;
                sx <= (sx == S_MAX) ? '0 : sx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     overflow_q <= 1'b0;
        else if (flush)                 overflow_q <= 1'b0;
        else if (keep && full && !pop)  overflow_q <= 1'b1;
    end

    rx_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (keep),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    assign bus.out_valid = !empty;
    assign bus.out_data  = dout[DATA_WIDTH-1:0];
    assign bus.out_last  = dout[DATA_WIDTH];
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_memtile_stream_rx_downsample.sv
module tb_memtile_stream_rx_downsample;
    import memtile_rx_pkg::*;

    localparam int W = 4, H = 4, S = 2, D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    memtile_stream_rx_downsample_if #(.DATA_WIDTH(16)) bus();

    memtile_stream_rx_downsample #(
        .DATA_WIDTH(16), .IMG_W(W), .IMG_H(H), .STRIDE(S), .FIFO_DEPTH(D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: pixel index within the frame gives raster position;
    // the output buffer is a plain queue.
    rx_entry_t mq[$];
    bit        movf;
    int        idx;
    int        mlog[$];
    bit        mlast_log[$];
    int        px, py;
    bit        m_full, m_pop, m_keep;
    rx_entry_t m_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            movf = 1'b0;
            idx  = 0;
        end else if (flush) begin
            mq.delete();
            movf = 1'b0;
            idx  = 0;
        end else begin
            px     = (idx % (W*H)) % W;
            py     = (idx % (W*H)) / W;
            m_keep = bus.in_valid && (px % S == 0) && (py % S == 0);
            m_full = (mq.size() == D);
            m_pop  = (mq.size() > 0) && bus.out_ready;
            if (m_pop) begin
                mlog.push_back(int'(mq[0].data));
                mlast_log.push_back(mq[0].last);
                void'(mq.pop_front());
            end
            if (m_keep) begin
                if (!m_full || m_pop) begin
                    m_e.data = bus.in_data;
                    // last kept pixel: no further grid point fits in row or column
                    m_e.last = (px + S >= W) && (py + S >= H);
                    mq.push_back(m_e);
                end else begin
                    movf = 1'b1;
                end
            end
            if (bus.in_valid) idx++;
        end
    end

    // Per-cycle comparison against the model.
    logic        exp_v, exp_l;
    logic [15:0] exp_d;
    always @(negedge clk) begin
        if (rst_n) begin
            exp_v = (mq.size() > 0);
            exp_d = exp_v ? mq[0].data : 16'd0;
            exp_l = exp_v ? mq[0].last : 1'b0;
            tests++;
            if (bus.out_valid !== exp_v || bus.out_data !== exp_d ||
                bus.out_last !== exp_l || bus.overflow !== movf) begin
                fails++;
                $display("FAIL cycle_cmp t=%0t got v=%b d=%0d l=%b o=%b want v=%b d=%0d l=%b o=%b",
                         $time, bus.out_valid, bus.out_data, bus.out_last, bus.overflow,
                         exp_v, exp_d, exp_l, movf);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic chk_log(input string name, input int off,
                           input int e0, input int e1, input int e2, input int e3,
                           input logic [3:0] el);
        int e[4];
        e = '{e0, e1, e2, e3};
        chk({name, "_len"}, (mlog.size() >= off + 4) ? 1 : 0, 1);
        if (mlog.size() >= off + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("%s_data%0d", name, i), mlog[off+i], e[i]);
                chk($sformatf("%s_last%0d", name, i), int'(mlast_log[off+i]), int'(el[i]));
            end
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'd0);
    endtask

    task automatic frame(input int base, input bit gaps);
        for (int i = 0; i < W*H; i++) begin
            step(1'b1, 16'(base + i));
            if (gaps) step(1'b0, 16'hDEAD);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step(1'b0, 16'd0);
        flush = 1'b0;
    endtask

    task automatic clear_log();
        mlog.delete();
        mlast_log.delete();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_data",  int'(bus.out_data),  0);
        chk("rst_last",  int'(bus.out_last),  0);
        chk("rst_ovf",   int'(bus.overflow),  0);
        rst_n = 1'b1;

        // Contiguous frame, always ready.
        clear_log();
        frame(0, 1'b0);
        idle(3);
        chk_log("t1", 0, 0, 2, 8, 10, 4'b1000);
        chk("t1_count", mlog.size(), 4);
        chk("t1_ovf", int'(bus.overflow), 0);

        // Gapped input gives the same result.
        clear_log();
        frame(0, 1'b1);
        idle(3);
        chk_log("t2", 0, 0, 2, 8, 10, 4'b1000);

        // Full FIFO, pop and push in the same cycle.
        do_flush();
        clear_log();
        bus.out_ready = 1'b0;
        frame(0, 1'b0);
        chk("t4_full", mq.size(), 4);
        chk("t4_full_valid", int'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        step(1'b1, 16'd100);
        chk("t4_size", mq.size(), 4);
        chk("t4_ovf", int'(bus.overflow), 0);
        chk("t4_head", int'(bus.out_data), 2);
        do_flush();

        // Overflow: second frame arrives while FIFO full and stalled.
        clear_log();
        bus.out_ready = 1'b0;
        frame(0, 1'b0);
        chk("t3_pre_ovf", int'(bus.overflow), 0);
        step(1'b1, 16'd100);
        chk("t3_ovf", int'(bus.overflow), 1);
        for (int i = 1; i < W*H; i++) step(1'b1, 16'(100 + i));
        bus.out_ready = 1'b1;
        idle(5);
        frame(200, 1'b0);
        idle(3);
        chk_log("t3a", 0, 0, 2, 8, 10, 4'b1000);
        chk_log("t3b", 4, 200, 202, 208, 210, 4'b1000);
        chk("t3_ovf_sticky", int'(bus.overflow), 1);

        // Flush mid-frame realigns the raster.
        do_flush();
        chk("t5_ovf_clr", int'(bus.overflow), 0);
        for (int i = 0; i < 6; i++) step(1'b1, 16'(i));
        do_flush();
        clear_log();
        frame(0, 1'b0);
        idle(3);
        chk_log("t5", 0, 0, 2, 8, 10, 4'b1000);

        // Asynchronous reset while the head carries last and overflow is set.
        bus.out_ready = 1'b0;
        frame(0, 1'b0);
        step(1'b1, 16'd100);
        bus.out_ready = 1'b1;
        idle(3);
        bus.out_ready = 1'b0;
        chk("t6_pre_last",  int'(bus.out_last),  1);
        chk("t6_pre_data",  int'(bus.out_data),  10);
        chk("t6_pre_ovf",   int'(bus.overflow),  1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", int'(bus.out_valid), 0);
        chk("t6_last",  int'(bus.out_last),  0);
        chk("t6_ovf",   int'(bus.overflow),  0);
        chk("t6_data",  int'(bus.out_data),  0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        clear_log();
        frame(0, 1'b0);
        idle(3);
        chk_log("t6", 0, 0, 2, 8, 10, 4'b1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memtile_stream_rx_downsample.md
Name: memtile_stream_rx_downsample

Overview:
- Receive side of the memtile read stream: consumes `valid_out`/`data_out` from a delay-configured memtile and performs the spatial down-sample.
- Tracks raster position x/y, keeps only pixels with x%STRIDE==0 and y%STRIDE==0, and buffers them in a small FIFO.
- Presents the kept pixels downstream on a ready/valid interface, with an end-of-frame marker.
- The memtile stream has no backpressure; this block absorbs stalls and flags any loss.

Parameters:
- DATA_WIDTH, 16, pixel width (matches memtile data_out lane).
- IMG_W, 64, pixels per row (>=1).
- IMG_H, 64, rows per frame (>=1).
- STRIDE, 2, down-sample factor in both dimensions (>=1).
- FIFO_DEPTH, 4, output buffer entries (power of two, >=2).

Ports:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous clear; same effect as reset, taken on clk edge.
- in_valid  in  1  memtile valid_out.
- in_data  in  DATA_WIDTH  memtile data_out lane 0.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH  head-of-FIFO pixel; 0 when empty.
- out_last  out  1  head pixel is the last kept pixel of its frame.
- overflow  out  1  sticky: a kept pixel was dropped because the FIFO was full.

Behaviour:
- Reset/flush values:
  - x=0, y=0; FIFO empty.
  - out_valid=0, out_data=0, out_last=0, overflow=0.
  - Reset acts immediately on rst_n low. Flush acts at the next clk edge and overrides any same-cycle push or pop.
- Position counters:
  - Advance only on cycles with in_valid=1. Gaps in in_valid are allowed and do not move x/y.
  - x increments and wraps at IMG_W-1, where y increments.
  - At x=IMG_W-1, y=IMG_H-1, both wrap to 0 and the next frame starts.
- Keep rule: keep = in_valid && (x%STRIDE==0) && (y%STRIDE==0).
  - Use a separate modulo counter per axis; no divider.
- Last flag:
  - LX = ((IMG_W-1)/STRIDE)*STRIDE and LY = ((IMG_H-1)/STRIDE)*STRIDE, computed as elaboration-time constants.
  - A kept pixel at x==LX && y==LY is stored with last=1.
- FIFO:
  - Each entry is {last, data}.
  - pop = out_valid && out_ready.
  - push = keep && (!full || pop): a push to a full FIFO is accepted when a pop happens in the same cycle.
  - keep && full && !pop: pixel dropped, overflow set to 1. Counters still advance.
  - overflow clears only on reset or flush.
- Latency: a pixel kept on cycle N is visible on out_valid/out_data/out_last on cycle N+1 when the FIFO was empty. No combinational path from in_* to out_*.
- Empty FIFO: pop is ignored and out_data=0. Full FIFO: out_valid stays 1.
- Count arithmetic: count width is clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package memtile_rx_pkg:
  - pixel_t (DATA_WIDTH logic vector).
  - rx_entry_t struct {last, pixel_t data}.
  - Helper function clog2_min1.
- Sub-module rx_fifo:
  - Synchronous, first-word-fall-through, parameterised on entry type width and depth.
  - Ports: push, pop, din, dout, full, empty.
  - The top module holds the counters, keep/last logic and the overflow flag.

Test Plan:
- IMG_W=4, IMG_H=4, STRIDE=2, out_ready=1, stream 0..15 contiguous -> out_data sequence 0,2,8,10; out_last=1 only on 10; overflow=0.
- Same config, in_valid toggled 1/0 every cycle over 0..15 -> identical output sequence 0,2,8,10 (gaps do not advance x/y).
- FIFO_DEPTH=4, out_ready=0; frame 0..15, then frame 100..115 -> FIFO holds 0,2,8,10; pixel 100 dropped and overflow=1 on the next cycle. Then out_ready=1 -> drains 0,2,8,10, then later-frame pixels as they arrive.
- FIFO full with out_ready=1 on the same cycle a kept pixel arrives -> push accepted, overflow stays 0, count stays 4.
- Flush after 6 input pixels, then stream 0..15 -> FIFO cleared, outputs 0,2,8,10 (frame realigned to x=0,y=0).
- Assert rst_n low mid-frame with FIFO non-empty -> out_valid, out_last and overflow go to 0 immediately without a clock edge; after release the next frame 0..15 yields 0,2,8,10.
